nonce_search_controller: RTL and testbench
==========================================

# nonce_search_controller

Drives `SHAcomputationalBlock` for one mining job. It builds the 640-bit message from a fixed 608-bit header prefix and a 32-bit nonce, and starts one hash per nonce. Each returned digest is compared against a 256-bit target, and the nonce steps until a hit, an attempt limit, or an abort. The block sits directly upstream of the SHA block and consumes its result.

## Interface
- `TOTAL_SIZE`, 640, message width presented to the SHA block
- `NONCE_WIDTH`, 32, nonce width; nonce occupies `inputMsg[NONCE_WIDTH-1:0]`
- `clk`  in  1  clock
- `n_rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin job; sampled only in IDLE, FOUND, EXHAUSTED
- `abort`  in  1  cancel job
- `headerPrefix`  in  TOTAL_SIZE-NONCE_WIDTH  header bits above the nonce
- `target`  in  256  unsigned threshold
- `startNonce`  in  NONCE_WIDTH  first nonce tried
- `maxAttempts`  in  32  attempt limit; 0 means 2^32
- `computationComplete`  in  1  SHA block done pulse
- `SHAoutput`  in  256  SHA digest; h0 is the MSW
- `inputMsg`  out  TOTAL_SIZE  `{headerPrefix_q, nonce_q}`
- `beginComputation`  out  1  one-cycle start to the SHA block
- `busy`  out  1  high in START, WAIT, CHECK, DRAIN
- `found`  out  1  high in FOUND
- `exhausted`  out  1  high in EXHAUSTED
- `goldenNonce`  out  NONCE_WIDTH  winning nonce
- `goldenHash`  out  256  winning digest
- `hashCount`  out  32  digests checked in current job

## Operation
- States: IDLE, START, WAIT, CHECK, FOUND, EXHAUSTED, DRAIN.
- Accepting `start` (with `abort` low, in IDLE, FOUND or EXHAUSTED):
  - Captures `headerPrefix`, `target`, `startNonce` into `nonce_q`, and `maxAttempts`.
  - Clears `hashCount`, `goldenNonce` and `goldenHash`, then enters START.
- START: `beginComputation`=1 for this cycle only, then WAIT.
- WAIT: holds until `computationComplete`. It then registers `SHAoutput` into `hash_q`, increments `hashCount`, and enters CHECK.
- CHECK, evaluated in priority order:
  - If `hash_q < target_q` (strict unsigned 256-bit): load `goldenNonce` from `nonce_q` and `goldenHash` from `hash_q`, then FOUND.
  - Else if `hashCount == maxAttempts_q` (32-bit compare; 0 matches after the 2^32 count wraps): EXHAUSTED.
  - Else `nonce_q <= nonce_q + 1` (mod 2^NONCE_WIDTH, wraps FFFFFFFF→0), then START.
- FOUND / EXHAUSTED: hold all outputs. Accepting `start` begins a new job directly.
- `abort`:
  - In START or CHECK: go to IDLE.
  - In WAIT with `computationComplete` low: go to DRAIN.
  - In WAIT with `computationComplete` high: go to IDLE and discard the result.
  - In FOUND or EXHAUSTED: go to IDLE, clearing `found` and `exhausted`.
  - In IDLE or DRAIN: no effect.
- DRAIN: waits for the outstanding `computationComplete`, discards it, then IDLE. This keeps a stale digest from being credited to the next job.
- `start` while `busy` is ignored. `start` together with `abort` in the same cycle: `abort` wins.
- `computationComplete` outside WAIT and DRAIN is ignored.
- `inputMsg` stays stable from START through the end of WAIT. It changes only on capture and on the CHECK increment.
- Reset: state IDLE; every output and internal register is 0.

## Timing
- `start` sampled at edge 0 → START in cycle 1, with `beginComputation`=1 and `inputMsg` valid.
- WAIT from cycle 2.
- `computationComplete` sampled at edge n → CHECK in cycle n+1.
- After CHECK, in cycle n+2, the block is in START (next nonce), FOUND, or EXHAUSTED.
- Overhead per nonce beyond SHA latency is 3 cycles: START, the sampling edge, and CHECK.
- `found`, `exhausted`, `goldenNonce` and `goldenHash` update on the same edge as the transition into FOUND or EXHAUSTED.
- `hashCount` updates on the edge leaving WAIT.
- Asynchronous reset mid-job forces IDLE immediately. The SHA block is reset by the same `n_rst`.

## Test plan
Bench stub SHA responder: asserts `computationComplete` 10 cycles after `beginComputation` and returns a programmed digest per nonce.

- Reset: assert `n_rst`=0 mid-WAIT → all outputs 0, `beginComputation`=0 in the next cycle.
- Hit on third attempt:
  - Stimulus: `startNonce`=FFFFFFFF, `target`=0x0001<<240; stub returns 0xFF..FF except 0x0000_00AB.. for nonce 00000001.
  - Response: `inputMsg` low word sequence FFFFFFFF, 00000000, 00000001; `found`=1, `goldenNonce`=00000001, `hashCount`=3.
  - Check exactly 3 `beginComputation` pulses, each at least 13 cycles apart.
- Equality is not a hit: digest == `target` with `maxAttempts`=1 → `exhausted`=1, `found`=0, `hashCount`=1.
- Abort during WAIT:
  - `abort` 4 cycles after `beginComputation` → DRAIN with `busy`=1.
  - `start` pulsed during DRAIN is ignored.
  - IDLE one cycle after the stub's `computationComplete`; `hashCount` stays 0.
- Back-to-back jobs: after FOUND, `start` with new `headerPrefix` and `startNonce`=00000010 → `found` clears and `hashCount` clears on capture; START next cycle with `inputMsg` low word 00000010.
- Simultaneous events:
  - `start` and `abort` high together in IDLE → stays IDLE.
  - `abort` coincident with `computationComplete` in WAIT → IDLE, no `found`.

Source files
------------

// File: rtl/nonce_search_controller.sv
// nonce_search_controller
// Sequences one mining job against an external SHA block. It presents
// {header prefix, nonce}, starts one hash per nonce and compares each digest
// against the job target. It stops on a hit, on the attempt limit, or on abort.
module nonce_search_controller #(
    parameter int unsigned TOTAL_SIZE  = 640,
    parameter int unsigned NONCE_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [TOTAL_SIZE-NONCE_WIDTH-1:0] headerPrefix,
    input  logic [255:0]                      target,
    input  logic [NONCE_WIDTH-1:0]            startNonce,
    input  logic [31:0]                       maxAttempts,
    input  logic                              computationComplete,
    input  logic [255:0]                      SHAoutput,
    output logic [TOTAL_SIZE-1:0]             inputMsg,
    output logic                              beginComputation,
    output logic                              busy,
    output logic                              found,
    output logic                              exhausted,
    output logic [NONCE_WIDTH-1:0]            goldenNonce,
    output logic [255:0]                      goldenHash,
    output logic [31:0]                       hashCount
);

    localparam int unsigned PrefixWidth = TOTAL_SIZE - NONCE_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StCheck,
        StFound,
        StExhausted,
        StDrain
    } state_t;

    state_t state_q, state_d;

    logic [PrefixWidth-1:0] headerPrefix_q;
    logic [255:0]           target_q;
    logic [NONCE_WIDTH-1:0] nonce_q;
    logic [31:0]            maxAttempts_q;
    logic [255:0]           hash_q;
    logic [31:0]            hashCount_q;
    logic [NONCE_WIDTH-1:0] goldenNonce_q;
    logic [255:0]           goldenHash_q;

    logic isHit;
    logic isLimit;
    logic acceptJob;
    logic captureHash;
    logic loadGolden;
    logic stepNonce;

    // Strict compare: a digest equal to the target is not a hit.
    assign isHit   = hash_q < target_q;
    // A limit of 0 matches once the 32-bit count wraps, i.e. after 2^32 digests.
    assign isLimit = hashCount_q == maxAttempts_q;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort always takes priority over start and completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = abort ? StIdle : StWait;
            end
            StWait: begin
                if (abort) begin
                    // A hash still in flight must be drained so it is not
                    // credited to the next job.
                    state_d = computationComplete ? StIdle : StDrain;
                end else if (computationComplete) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (isHit) begin
                    state_d = StFound;
                end else if (isLimit) begin
                    state_d = StExhausted;
                end else begin
                    state_d = StStart;
                end
            end
            StFound, StExhausted: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StStart;
                end
            end
            StDrain: begin
                if (computationComplete) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath load enables derived from the current state and inputs.
    always_comb begin
        acceptJob   = 1'b0;
        captureHash = 1'b0;
        loadGolden  = 1'b0;
        stepNonce   = 1'b0;
        if ((state_q == StIdle || state_q == StFound || state_q == StExhausted)
            && start && !abort) begin
            acceptJob = 1'b1;
        end
        if (state_q == StWait && computationComplete && !abort) begin
            captureHash = 1'b1;
        end
        if (state_q == StCheck && !abort) begin
            loadGolden = isHit;
            stepNonce  = !isHit && !isLimit;
        end
    end

    // Job parameters, nonce, digest and result registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            headerPrefix_q <= '0;
            target_q       <= '0;
            nonce_q        <= '0;
            maxAttempts_q  <= '0;
            hash_q         <= '0;
            hashCount_q    <= '0;
            goldenNonce_q  <= '0;
            goldenHash_q   <= '0;
        end else begin
            if (acceptJob) begin
                headerPrefix_q <= headerPrefix;
                target_q       <= target;
                nonce_q        <= startNonce;
                maxAttempts_q  <= maxAttempts;
                hashCount_q    <= '0;
                goldenNonce_q  <= '0;
                goldenHash_q   <= '0;
            end
            if (captureHash) begin
                hash_q      <= SHAoutput;
                hashCount_q <= hashCount_q + 32'd1;
            end
            if (loadGolden) begin
                goldenNonce_q <= nonce_q;
                goldenHash_q  <= hash_q;
            end
            if (stepNonce) begin
                nonce_q <= nonce_q + NONCE_WIDTH'(1);
            end
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        beginComputation = 1'b0;
        busy             = 1'b0;
        found            = 1'b0;
        exhausted        = 1'b0;
        unique case (state_q)
            StStart: begin
                beginComputation = 1'b1;
                busy             = 1'b1;
            end
            StWait, StCheck, StDrain: busy      = 1'b1;
            StFound:                  found     = 1'b1;
            StExhausted:              exhausted = 1'b1;
            default: ;
        endcase
    end

    assign inputMsg    = {headerPrefix_q, nonce_q};
    assign goldenNonce = goldenNonce_q;
    assign goldenHash  = goldenHash_q;
    assign hashCount   = hashCount_q;

endmodule

// File: tb/tb_nonce_search_controller.sv
// Scoreboard bench for nonce_search_controller with a stub SHA responder.
module tb_nonce_search_controller;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic         abort;
    logic [607:0] headerPrefix;
    logic [255:0] target;
    logic [31:0]  startNonce;
    logic [31:0]  maxAttempts;
    logic         computationComplete;
    logic [255:0] SHAoutput;
    logic [639:0] inputMsg;
    logic         beginComputation;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [31:0]  goldenNonce;
    logic [255:0] goldenHash;
    logic [31:0]  hashCount;

    nonce_search_controller #(
        .TOTAL_SIZE (640),
        .NONCE_WIDTH(32)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start              (start),
        .abort              (abort),
        .headerPrefix       (headerPrefix),
        .target             (target),
        .startNonce         (startNonce),
        .maxAttempts        (maxAttempts),
        .computationComplete(computationComplete),
        .SHAoutput          (SHAoutput),
        .inputMsg           (inputMsg),
        .beginComputation   (beginComputation),
        .busy               (busy),
        .found              (found),
        .exhausted          (exhausted),
        .goldenNonce        (goldenNonce),
        .goldenHash         (goldenHash),
        .hashCount          (hashCount)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic         f;
        logic         e;
        logic [31:0]  gn;
        logic [255:0] gh;
        logic [31:0]  hc;
    } res_t;

    logic [639:0] expBeginQ[$];
    res_t         expResQ[$];
    int           beginCycQ[$];

    // Programmed digest table: one nonce may return hitDigest, all others all-ones.
    logic         hitEn;
    logic [31:0]  hitNonce;
    logic [255:0] hitDigest;

    function automatic logic [255:0] digestFor(input logic [31:0] n);
        return (hitEn && n == hitNonce) ? hitDigest : {256{1'b1}};
    endfunction

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stub SHA block: completes 10 cycles after sampling beginComputation.
    int          stubCnt;
    logic [31:0] stubNonce;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stubCnt             <= 0;
            stubNonce           <= '0;
            computationComplete <= 1'b0;
            SHAoutput           <= '0;
        end else begin
            computationComplete <= 1'b0;
            if (beginComputation) begin
                stubCnt   <= 10;
                stubNonce <= inputMsg[31:0];
            end else if (stubCnt > 0) begin
                stubCnt <= stubCnt - 1;
                if (stubCnt == 1) begin
                    computationComplete <= 1'b1;
                    SHAoutput           <= digestFor(stubNonce);
                end
            end
        end
    end

    // Monitor: pops expectations whenever a hash starts or a job ends.
    logic prevDone = 1'b0;
    always @(negedge clk) begin
        logic [639:0] eMsg;
        res_t         r;
        if (!n_rst) begin
            prevDone = 1'b0;
        end else begin
            if (beginComputation) begin
                beginCycQ.push_back(cyc);
                chk("begin expected", 640'(expBeginQ.size() != 0), 640'(1));
                if (expBeginQ.size() != 0) begin
                    eMsg = expBeginQ.pop_front();
                    chk("inputMsg", inputMsg, eMsg);
                end
            end
            if ((found || exhausted) && !prevDone) begin
                chk("result expected", 640'(expResQ.size() != 0), 640'(1));
                if (expResQ.size() != 0) begin
                    r = expResQ.pop_front();
                    chk("found", 640'(found), 640'(r.f));
                    chk("exhausted", 640'(exhausted), 640'(r.e));
                    chk("goldenNonce", 640'(goldenNonce), 640'(r.gn));
                    chk("goldenHash", 640'(goldenHash), 640'(r.gh));
                    chk("hashCount", 640'(hashCount), 640'(r.hc));
                    chk("busy at done", 640'(busy), 640'(0));
                end
            end
            prevDone = found || exhausted;
        end
    end

    // Reference: walk the nonces in order; first digest below target wins,
    // otherwise stop when the count reaches the limit (0 = 2^32).
    task automatic modelJob(input logic [607:0] hdr, input logic [255:0] tgt,
                            input logic [31:0] sn, input logic [31:0] maxA);
        res_t         r;
        logic [31:0]  n;
        logic [31:0]  cnt;
        logic [255:0] d;
        for (int k = 0; k < 64; k++) begin
            n   = sn + 32'(k);
            cnt = 32'(k + 1);
            expBeginQ.push_back({hdr, n});
            d = digestFor(n);
            if (d < tgt) begin
                r.f = 1'b1; r.e = 1'b0; r.gn = n; r.gh = d; r.hc = cnt;
                expResQ.push_back(r);
                return;
            end
            if (cnt == maxA) begin
                r.f = 1'b0; r.e = 1'b1; r.gn = '0; r.gh = '0; r.hc = cnt;
                expResQ.push_back(r);
                return;
            end
        end
    endtask

    function automatic logic [607:0] randHdr();
        logic [607:0] h;
        for (int i = 0; i < 19; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    function automatic logic [255:0] randWide();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v == '0) v = 256'd1;
        return v;
    endfunction

    // Presents a job for one cycle; returns at the negedge after the capture edge.
    task automatic launch(input logic [607:0] hdr, input logic [255:0] tgt,
                          input logic [31:0] sn, input logic [31:0] maxA);
        @(negedge clk);
        headerPrefix = hdr;
        target       = tgt;
        startNonce   = sn;
        maxAttempts  = maxA;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int i = 0;
        while (!(found || exhausted) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("job completes", 640'(found || exhausted), 640'(1));
    endtask

    task automatic waitComplete(input int budget);
        int i = 0;
        while (!computationComplete && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("stub completion seen", 640'(computationComplete), 640'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [607:0] hdr;
        logic [255:0] tgt;
        logic [31:0]  sn;
        logic [31:0]  maxA;
        int           mode;

        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        headerPrefix = '0; target = '0; startNonce = '0; maxAttempts = '0;
        hitEn = 1'b0; hitNonce = '0; hitDigest = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 640'(busy), 640'(0));
        chk("reset found", 640'(found), 640'(0));
        chk("reset inputMsg", inputMsg, 640'(0));
        chk("reset hashCount", 640'(hashCount), 640'(0));
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Hit on the third attempt across the nonce wrap.
        hdr = randHdr();
        tgt = 256'd1 << 240;
        hitEn = 1'b1; hitNonce = 32'd1; hitDigest = 256'hAB << 224;
        modelJob(hdr, tgt, 32'hFFFF_FFFF, 32'd0);
        beginCycQ.delete();
        launch(hdr, tgt, 32'hFFFF_FFFF, 32'd0);
        waitDone(200);
        chk("hit3 found", 640'(found), 640'(1));
        chk("hit3 goldenNonce", 640'(goldenNonce), 640'(1));
        chk("hit3 hashCount", 640'(hashCount), 640'(3));
        chk("hit3 pulse count", 640'(beginCycQ.size()), 640'(3));
        for (int i = 1; i < beginCycQ.size(); i++)
            chk("hit3 pulse spacing >= 13", 640'(beginCycQ[i] - beginCycQ[i-1] >= 13), 640'(1));

        // Back-to-back job straight out of FOUND.
        hdr = randHdr();
        tgt = randWide();
        hitEn = 1'b1; hitNonce = 32'h12; hitDigest = '0;
        modelJob(hdr, tgt, 32'h10, 32'd8);
        launch(hdr, tgt, 32'h10, 32'd8);
        chk("b2b found cleared", 640'(found), 640'(0));
        chk("b2b hashCount cleared", 640'(hashCount), 640'(0));
        chk("b2b begin", 640'(beginComputation), 640'(1));
        chk("b2b nonce word", 640'(inputMsg[31:0]), 640'(32'h10));
        waitDone(200);

        // Digest equal to target is not a hit.
        hdr = randHdr();
        tgt = randWide();
        sn  = $urandom;
        hitEn = 1'b1; hitNonce = sn; hitDigest = tgt;
        modelJob(hdr, tgt, sn, 32'd1);
        launch(hdr, tgt, sn, 32'd1);
        waitDone(100);
        chk("eq exhausted", 640'(exhausted), 640'(1));
        chk("eq found", 640'(found), 640'(0));

        // Abort out of EXHAUSTED.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort exh clears exhausted", 640'(exhausted), 640'(0));
        chk("abort exh idle", 640'(busy), 640'(0));

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start+abort stays idle", 640'(busy), 640'(0));
            @(negedge clk);
        end

        // Abort during WAIT drains the outstanding hash.
        hdr = randHdr(); tgt = randWide(); sn = $urandom;
        hitEn = 1'b0;
        expBeginQ.push_back({hdr, sn});
        launch(hdr, tgt, sn, 32'd5);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("drain busy", 640'(busy), 640'(1));
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("drain ignores start", 640'(busy), 640'(1));
        waitComplete(40);
        chk("drain busy at completion", 640'(busy), 640'(1));
        @(negedge clk);
        chk("drain idle after completion", 640'(busy), 640'(0));
        chk("drain hashCount", 640'(hashCount), 640'(0));
        repeat (16) @(negedge clk);
        chk("drain stays idle", 640'(busy), 640'(0));

        // Abort coincident with completion: result discarded.
        hdr = randHdr(); tgt = randWide(); sn = $urandom;
        hitEn = 1'b1; hitNonce = sn; hitDigest = '0;
        expBeginQ.push_back({hdr, sn});
        launch(hdr, tgt, sn, 32'd5);
        waitComplete(40);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("coincident abort idle", 640'(busy), 640'(0));
        chk("coincident abort no found", 640'(found), 640'(0));
        chk("coincident abort hashCount", 640'(hashCount), 640'(0));

        // Asynchronous reset mid-WAIT.
        hdr = randHdr(); tgt = randWide(); sn = $urandom | 32'h1;
        hitEn = 1'b0;
        expBeginQ.push_back({hdr, sn});
        launch(hdr, tgt, sn, 32'd5);
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("rst inputMsg", inputMsg, 640'(0));
        chk("rst busy", 640'(busy), 640'(0));
        chk("rst found", 640'(found), 640'(0));
        chk("rst exhausted", 640'(exhausted), 640'(0));
        chk("rst goldenNonce", 640'(goldenNonce), 640'(0));
        chk("rst goldenHash", 640'(goldenHash), 640'(0));
        chk("rst hashCount", 640'(hashCount), 640'(0));
        @(negedge clk);
        chk("rst beginComputation", 640'(beginComputation), 640'(0));
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized jobs.
        for (int j = 0; j < 20; j++) begin
            hdr  = randHdr();
            tgt  = randWide();
            sn   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            maxA = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
            hitEn    = (maxA == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            hitNonce = sn + 32'($urandom_range(0, 7));
            mode     = (maxA == 0) ? 0 : $urandom_range(0, 2);
            if (mode == 0) hitDigest = tgt >> $urandom_range(1, 8);
            else if (mode == 1) hitDigest = tgt;
            else hitDigest = (tgt == '1) ? tgt : tgt + 256'd1;
            modelJob(hdr, tgt, sn, maxA);
            launch(hdr, tgt, sn, maxA);
            waitDone(300);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk); abort = 1'b1;
                @(negedge clk); abort = 1'b0;
                chk("rand abort clears found", 640'(found), 640'(0));
                chk("rand abort clears exhausted", 640'(exhausted), 640'(0));
            end
        end

        repeat (3) @(negedge clk);
        chk("begin queue drained", 640'(expBeginQ.size()), 640'(0));
        chk("result queue drained", 640'(expResQ.size()), 640'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
